// File: rtl/window_stream_buffer.sv
// Sliding FILTER_SIZE x FILTER_SIZE window generator over a raster pixel stream.
// Line memories hold the previous rows; a column tap register forms the window.
module window_stream_buffer #(
  parameter int FILTER_SIZE = 3,
  parameter int IMAGE_SIZE  = 28,
  parameter int I_WIDTH     = 8,
  parameter int CHANNELS    = 1,
  parameter int STRIDE      = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clk_en,
  input  logic flush,
  input  logic in_valid,
  input  logic [I_WIDTH*CHANNELS-1:0] in_data,
  output logic out_valid,
  output logic [I_WIDTH*CHANNELS*FILTER_SIZE*FILTER_SIZE-1:0] out_data,
  output logic [$clog2(IMAGE_SIZE)-1:0] out_row,
  output logic [$clog2(IMAGE_SIZE)-1:0] out_col,
  output logic frame_done
);

  localparam int F  = FILTER_SIZE;
  localparam int PW = I_WIDTH * CHANNELS;
  localparam int WW = PW * F * F;
  localparam int AW = $clog2(IMAGE_SIZE);
  localparam int SW = (STRIDE > 1) ? $clog2(STRIDE) : 1;
  localparam logic [AW-1:0] LAST  = AW'(IMAGE_SIZE - 1);
  localparam logic [AW-1:0] EDGE  = AW'(F - 1);
  localparam logic [SW-1:0] SLAST = SW'(STRIDE - 1);

  logic [AW-1:0] col, row;
  logic [SW-1:0] col_ph, row_ph;
  logic [SW-1:0] col_ph_nxt, row_ph_nxt;
  logic [PW-1:0] line_mem [F-1][IMAGE_SIZE];
  logic [PW-1:0] taps [F][F-1];
  logic [PW-1:0] col_vec [F];
  logic [WW-1:0] win_next;
  logic accept, qualify, last_col, last_row;

  assign accept   = clk_en && in_valid && !flush;
  assign last_col = (col == LAST);
  assign last_row = (row == LAST);
  assign qualify  = (row >= EDGE) && (col >= EDGE) &&
                    (row_ph == '0) && (col_ph == '0);

  // Phases only start counting once the first full window column is reached.
  always_comb begin
    col_ph_nxt = '0;
    row_ph_nxt = '0;
    if (col >= EDGE && col_ph != SLAST)
      col_ph_nxt = col_ph + 1'b1;
    if (row >= EDGE && row_ph != SLAST)
      row_ph_nxt = row_ph + 1'b1;
  end

  always_comb begin
    for (int i = 0; i < F-1; i++)
      col_vec[i] = line_mem[i][col];
    col_vec[F-1] = in_data;
  end

  always_comb begin
    win_next = '0;
    for (int i = 0; i < F; i++) begin
      for (int j = 0; j < F-1; j++)
        win_next[(i*F+j)*PW +: PW] = taps[i][j];
      win_next[(i*F+F-1)*PW +: PW] = col_vec[i];
    end
  end

  // Storage content is don't-care after reset, so it carries no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int k = 0; k < F-2; k++)
        line_mem[k][col] <= line_mem[k+1][col];
      line_mem[F-2][col] <= in_data;
      for (int i = 0; i < F; i++) begin
        for (int j = 0; j < F-2; j++)
          taps[i][j] <= taps[i][j+1];
        taps[i][F-2] <= col_vec[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col        <= '0;
      row        <= '0;
      col_ph     <= '0;
      row_ph     <= '0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      out_data   <= '0;
      out_row    <= '0;
      out_col    <= '0;
    end else if (clk_en) begin
      if (flush) begin
        col        <= '0;
        row        <= '0;
        col_ph     <= '0;
        row_ph     <= '0;
        out_valid  <= 1'b0;
        frame_done <= 1'b0;
      end else begin
        out_valid  <= in_valid && qualify;
        frame_done <= in_valid && last_col && last_row;
        if (in_valid) begin
          if (qualify) begin
            out_data <= win_next;
            out_row  <= row;
            out_col  <= col;
          end
          if (last_col) begin
            col    <= '0;
            col_ph <= '0;
            row    <= last_row ? '0 : row + 1'b1;
            row_ph <= last_row ? '0 : row_ph_nxt;
          end else begin
            col    <= col + 1'b1;
            col_ph <= col_ph_nxt;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_window_stream_buffer.sv
// Randomised bench for window_stream_buffer: two configurations against a
// frame-image reference model plus literal window expectations.
module tb_window_stream_buffer;

  logic clk = 1'b0;
  logic rst_n, clk_en, flush, in_valid;
  logic [7:0] dval [2][3];
  logic [7:0] din_a;
  logic [23:0] din_b;
  logic ova, ovb, doa, dob;
  logic [71:0] oda;
  logic [215:0] odb;
  logic [1:0] ora, oca;
  logic [2:0] orb, ocb;

  assign din_a = dval[0][0];
  assign din_b = {dval[1][2], dval[1][1], dval[1][0]};

  always #5 clk = ~clk;

  window_stream_buffer #(
    .FILTER_SIZE(3), .IMAGE_SIZE(4), .I_WIDTH(8),
    .CHANNELS(1), .STRIDE(1)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .flush(flush),
    .in_valid(in_valid), .in_data(din_a), .out_valid(ova),
    .out_data(oda), .out_row(ora), .out_col(oca), .frame_done(doa)
  );

  window_stream_buffer #(
    .FILTER_SIZE(3), .IMAGE_SIZE(5), .I_WIDTH(8),
    .CHANNELS(3), .STRIDE(2)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .flush(flush),
    .in_valid(in_valid), .in_data(din_b), .out_valid(ovb),
    .out_data(odb), .out_row(orb), .out_col(ocb), .frame_done(dob)
  );

  int nn [2] = '{4, 5};
  int nc [2] = '{1, 3};
  int ns [2] = '{1, 2};

  int ncmp = 0;
  int nerr = 0;
  bit chk_on = 0;
  bit rnd_mode = 0;

  // reference model: image array indexed by position, windows by arithmetic
  int mr [2], mc [2], mframe [2];
  logic [7:0] img [2][5][5][3];
  logic ev [2], ed [2];
  logic [215:0] edata [2];
  int erow [2], ecol [2], eframe [2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        mr[d] = 0; mc[d] = 0; mframe[d] = 0;
        ev[d] = 0; ed[d] = 0; edata[d] = '0;
        erow[d] = 0; ecol[d] = 0; eframe[d] = 0;
      end
    end else if (clk_en) begin
      for (int d = 0; d < 2; d++) begin
        if (flush) begin
          mr[d] = 0; mc[d] = 0; mframe[d] = 0;
          ev[d] = 0; ed[d] = 0;
        end else if (in_valid) begin
          bit q;
          for (int k = 0; k < nc[d]; k++)
            img[d][mr[d]][mc[d]][k] = dval[d][k];
          q = mr[d] >= 2 && mc[d] >= 2 &&
              (mr[d] - 2) % ns[d] == 0 && (mc[d] - 2) % ns[d] == 0;
          ev[d] = q;
          if (q) begin
            for (int i = 0; i < 3; i++)
              for (int j = 0; j < 3; j++)
                for (int k = 0; k < nc[d]; k++)
                  edata[d][((i*3+j)*nc[d]+k)*8 +: 8] =
                    img[d][mr[d]-2+i][mc[d]-2+j][k];
            erow[d] = mr[d];
            ecol[d] = mc[d];
            eframe[d] = mframe[d];
          end
          ed[d] = (mr[d] == nn[d]-1) && (mc[d] == nn[d]-1);
          if (mc[d] == nn[d]-1) begin
            mc[d] = 0;
            if (mr[d] == nn[d]-1) begin
              mr[d] = 0;
              mframe[d]++;
            end else mr[d]++;
          end else mc[d]++;
        end else begin
          ev[d] = 0; ed[d] = 0;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [215:0] act,
                     input logic [215:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  localparam logic [71:0] LIT_A0 =
    {8'd11, 8'd10, 8'd9, 8'd7, 8'd6, 8'd5, 8'd3, 8'd2, 8'd1};
  localparam logic [71:0] LIT_A1 =
    {8'd61, 8'd60, 8'd59, 8'd57, 8'd56, 8'd55, 8'd53, 8'd52, 8'd51};
  int lit_b [9] = '{13, 14, 15, 18, 19, 20, 23, 24, 25};

  always @(negedge clk) begin
    if (chk_on) begin
      chk("a_valid", 216'(ova), 216'(ev[0]));
      chk("a_done", 216'(doa), 216'(ed[0]));
      chk("a_row", 216'(ora), 216'(erow[0]));
      chk("a_col", 216'(oca), 216'(ecol[0]));
      chk("a_data", 216'(oda), edata[0]);
      chk("b_valid", 216'(ovb), 216'(ev[1]));
      chk("b_done", 216'(dob), 216'(ed[1]));
      chk("b_row", 216'(orb), 216'(erow[1]));
      chk("b_col", 216'(ocb), 216'(ecol[1]));
      chk("b_data", odb, edata[1]);
      if (!rnd_mode && ev[0] && erow[0] == 2 && ecol[0] == 2)
        chk(eframe[0] % 2 == 0 ? "a_lit_first" : "a_lit_frame2",
            216'(oda), eframe[0] % 2 == 0 ? 216'(LIT_A0) : 216'(LIT_A1));
      if (!rnd_mode && ev[1] && erow[1] == 4 && ecol[1] == 4 &&
          eframe[1] % 2 == 0) begin
        logic [215:0] t;
        t = '0;
        for (int e = 0; e < 9; e++)
          for (int k = 0; k < 3; k++)
            t[(e*3+k)*8 +: 8] = 8'(lit_b[e] + 100*k);
        chk("b_lit_44", odb, t);
      end
    end
  end

  function automatic logic [7:0] pix(int d, int k);
    int p;
    p = nn[d]*mr[d] + mc[d] + 1 + 50*(mframe[d] % 2) + 100*k;
    return 8'(p);
  endfunction

  task automatic step(input bit v, input bit en, input bit fl);
    @(posedge clk);
    #1;
    in_valid = v;
    clk_en = en;
    flush = fl;
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < 3; k++)
        dval[d][k] = rnd_mode ? 8'($urandom) : pix(d, k);
  endtask

  task automatic reset_check(input string nm);
    @(negedge clk);
    chk(nm, 216'({ova, doa, ora, oca, oda}), '0);
    chk({nm, "_b"}, 216'({ovb, dob, orb, ocb}), '0);
    chk({nm, "_bdata"}, odb, '0);
  endtask

  task automatic align_a(input int idx);
    for (int t = 0; t < 60; t++) begin
      if (mr[0]*4 + mc[0] == idx) break;
      step(1, 1, 0);
    end
    chk("align_a", 216'(mr[0]*4 + mc[0]), 216'(idx));
  endtask

  initial begin
    int cnt;
    int rq [$];
    int cq [$];
    int er [4] = '{2, 2, 3, 3};
    int ec [4] = '{2, 3, 2, 3};
    bit seen, coinc;

    rst_n = 1'b0; clk_en = 1'b0; flush = 1'b0; in_valid = 1'b0;
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < 3; k++) dval[d][k] = '0;
    repeat (2) @(posedge clk);
    chk_on = 1;
    reset_check("reset_state");
    @(posedge clk); #1 rst_n = 1'b1;

    // first frame without bubbles: pulse count, coordinates, frame_done
    cnt = 0; seen = 0; coinc = 0;
    for (int t = 0; t < 40 && !seen; t++) begin
      step(1, 1, 0);
      @(negedge clk);
      if (ova) begin
        cnt++;
        rq.push_back(int'(ora));
        cq.push_back(int'(oca));
      end
      if (doa) begin
        seen = 1;
        coinc = ova;
      end
    end
    chk("a_done_seen", 216'(seen), 216'(1));
    chk("a_pulse_count", 216'(cnt), 216'(4));
    chk("a_done_with_valid", 216'(coinc), 216'(1));
    for (int i = 0; i < 4 && i < rq.size(); i++) begin
      chk("a_pulse_row", 216'(rq[i]), 216'(er[i]));
      chk("a_pulse_col", 216'(cq[i]), 216'(ec[i]));
    end
    repeat (60) step(1, 1, 0);

    // bubbles and clock-enable gaps
    repeat (400)
      step($urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0, 0);

    // asynchronous reset in the middle of a frame
    step(1, 1, 1);
    align_a(6);
    #2 rst_n = 1'b0;
    reset_check("midframe_reset");
    step(0, 1, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (70) step(1, 1, 0);

    // flush in the middle of a frame, with in_valid high
    step(1, 1, 1);
    align_a(6);
    step(1, 1, 1);
    @(negedge clk);
    chk("flush_valid", 216'({ova, doa, ovb, dob}), '0);
    repeat (70) step(1, 1, 0);

    // random data, bubbles, enable gaps and occasional flush
    rnd_mode = 1;
    step(1, 1, 1);
    repeat (500)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0,
           $urandom_range(0, 40) == 0);
    step(0, 1, 0);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
